ctrl_fsm: RTL
=============

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter IW, default 9, instruction width in bits (IW >= OPW+1).
REQ-002 SHALL have parameter OPW, default 4, opcode field width, taken as Instruction[IW-2 -: OPW].
REQ-003 SHALL have parameter MEM_LAT, default 1, load latency in cycles, legal range 1..8.
REQ-004 SHALL have parameter CNTW, default 16, width of the retired-instruction counter.
REQ-005 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port Start, input, 1, begins execution from IDLE or HALT.
REQ-008 SHALL have port Instruction, input, IW, the current machine word.
REQ-009 SHALL have port ZERO, input, 1, ALU result-is-zero flag.
REQ-010 SHALL have ports MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM, LOOKUP, branch, outputs, 1 each, datapath enables.
REQ-011 SHALL have port PC_EN, output, 1, fetch unit advances when high.
REQ-012 SHALL have port done, output, 1, program finished.
REQ-013 SHALL have port instr_count, output, CNTW, retired-instruction count.

Function
REQ-014 SHALL implement the states IDLE, RUN, MEM_WAIT and HALT, with the state held in a register.
REQ-015 IDLE: all enables, PC_EN and done SHALL be 0; Start=1 moves the block to RUN and clears instr_count.
REQ-016 RUN, Instruction[IW-1]=1: branch SHALL be 1, all other enables 0, PC_EN=1.
REQ-017 RUN, opcode decode: 9 -> REG_WRITE; 11 -> load; 12 -> MEM_WRITE; 13 -> halt; 14 -> ACC_WRITE+LOOKUP; every other opcode -> ACC_WRITE only. In each case PC_EN=1 unless REQ-018..020 overrides it.
REQ-018 Load with MEM_LAT=1: MEM_READ, IS_MEM, ACC_WRITE and PC_EN SHALL all be 1 in the same cycle, and the state SHALL remain RUN.
REQ-019 Load with MEM_LAT>1: in the RUN cycle MEM_READ=IS_MEM=1 and ACC_WRITE=PC_EN=0; the wait counter SHALL load MEM_LAT-1 and the state SHALL move to MEM_WAIT.
REQ-020 MEM_WAIT: MEM_READ=IS_MEM=1 and the counter decrements each cycle. While the counter >1, PC_EN=ACC_WRITE=0. When the counter =1, ACC_WRITE=PC_EN=1 and the state returns to RUN. A load SHALL therefore occupy exactly MEM_LAT cycles.
REQ-021 Opcode 13 in RUN: all enables and PC_EN SHALL be 0, and the state SHALL move to HALT.
REQ-022 HALT: done=1 (from state), PC_EN=0, all enables 0. Start=1 moves the block to RUN, clears instr_count, and done falls in the first RUN cycle.
REQ-023 Start SHALL be ignored in RUN and MEM_WAIT.
REQ-024 instr_count SHALL increment on every edge where PC_EN=1.
REQ-025 instr_count SHALL saturate at 2^CNTW-1 and SHALL NOT wrap.
REQ-026 Instruction and ZERO SHALL be sampled combinationally. The Instruction value at the end of MEM_WAIT is don't-care, because the fetch unit holds it while PC_EN=0.

Reset
REQ-027 Reset_n low SHALL asynchronously force: state IDLE, wait counter 0, instr_count 0, and all outputs 0, including done and PC_EN.
REQ-028 Reset asserted in MEM_WAIT or HALT SHALL abort the operation with no residual enable on the next cycle; release returns the block to IDLE.

Configuration
REQ-029 With macro CTRL_COND_BRANCH_EN defined: branch=Instruction[IW-1] AND ZERO in RUN, and PC_EN=1 regardless of the branch outcome.
REQ-030 With CTRL_COND_BRANCH_EN undefined: branch=Instruction[IW-1] in RUN, and ZERO SHALL be ignored.

Verification
REQ-031 Reset, Start pulse, then opcodes 0, 9, 12 -> ACC_WRITE, REG_WRITE and MEM_WRITE each asserted for 1 cycle, PC_EN=1 throughout, instr_count=3.
REQ-032 MEM_LAT=3, opcode 11 -> MEM_READ/IS_MEM high 3 cycles, ACC_WRITE and PC_EN high only in the 3rd, instr_count +1.
REQ-033 Opcode 13, then Start after 4 idle cycles -> done=1 for those cycles with PC_EN=0, then done=0 and instr_count=0.
REQ-034 Instruction=9'h100 with ZERO=0 then ZERO=1 -> branch 0 then 1 with macro defined; branch 1 then 1 without the macro.
REQ-035 Reset_n pulsed low mid-MEM_WAIT -> all outputs 0 immediately; IDLE after release; Start required to resume.
REQ-036 CNTW=4, 20 consecutive ALU opcodes -> instr_count holds 15.

Source files
------------

// File: rtl/ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ctrl_fsm -- instruction-level control sequencer
//
// Decodes the current machine word and drives the datapath enables. Loads
// can stall for MEM_LAT cycles. The block also keeps a saturating count of
// retired instructions.
//
// Parameters
//   IW      instruction width; the MSB is the branch flag (IW >= OPW+1)
//   OPW     opcode width, taken as Instruction[IW-2 -: OPW]
//   MEM_LAT load latency in cycles (1..8)
//   CNTW    width of the retired-instruction counter
//
// Ports
//   Clk          single clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Start        begins execution from IDLE or HALT
//   Instruction  current machine word (combinational)
//   ZERO         ALU result-is-zero flag (combinational)
//   MEM_READ, MEM_WRITE, REG_WRITE, ACC_WRITE, IS_MEM, LOOKUP, branch
//                datapath enables
//   PC_EN        fetch unit advances when high
//   done         program finished (HALT state)
//   instr_count  retired-instruction count, saturating
//
// Build option
//   CTRL_COND_BRANCH_EN  when defined, branch = Instruction[IW-1] & ZERO;
//                        otherwise branch = Instruction[IW-1] and ZERO is unused.
// -----------------------------------------------------------------------------
module ctrl_fsm #(
  parameter int IW      = 9,
  parameter int OPW     = 4,
  parameter int MEM_LAT = 1,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [IW-1:0]   Instruction,
  input  logic            ZERO,
  output logic            MEM_READ,
  output logic            MEM_WRITE,
  output logic            REG_WRITE,
  output logic            ACC_WRITE,
  output logic            IS_MEM,
  output logic            LOOKUP,
  output logic            branch,
  output logic            PC_EN,
  output logic            done,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [OPW-1:0] OP_REG   = OPW'(9);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(11);
  localparam logic [OPW-1:0] OP_STORE = OPW'(12);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(13);
  localparam logic [OPW-1:0] OP_LUT   = OPW'(14);

  // MEM_LAT <= 8, so MEM_LAT-1 always fits in four bits.
  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_wait;
  logic [3:0]      w_wait_next;
  logic [CNTW-1:0] r_count;
  logic            w_cnt_clr;
  logic [OPW-1:0]  w_opcode;

  assign w_opcode    = Instruction[IW-2 -: OPW];
  assign instr_count = r_count;

  // NOTE: every output and next-state signal gets a default before the case
  // statement, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_cnt_clr    = 1'b0;
    MEM_READ     = 1'b0;
    MEM_WRITE    = 1'b0;
    REG_WRITE    = 1'b0;
    ACC_WRITE    = 1'b0;
    IS_MEM       = 1'b0;
    LOOKUP       = 1'b0;
    branch       = 1'b0;
    PC_EN        = 1'b0;
    done         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_next = S_RUN;
          w_cnt_clr    = 1'b1;
        end
      end

      S_RUN: begin
        if (Instruction[IW-1]) begin
`ifdef CTRL_COND_BRANCH_EN
          branch = ZERO;
`else
          branch = 1'b1;
`endif
          PC_EN  = 1'b1;
        end else begin
          unique case (w_opcode)
            OP_REG: begin
              REG_WRITE = 1'b1;
              PC_EN     = 1'b1;
            end
            OP_LOAD: begin
              MEM_READ = 1'b1;
              IS_MEM   = 1'b1;
              if (MEM_LAT == 1) begin
                // Single-cycle memory: data lands in the same cycle.
                ACC_WRITE = 1'b1;
                PC_EN     = 1'b1;
              end else begin
                // This RUN cycle is the first load cycle; wait out the rest.
                w_wait_next  = WAIT_INIT;
                w_state_next = S_MEM_WAIT;
              end
            end
            OP_STORE: begin
              MEM_WRITE = 1'b1;
              PC_EN     = 1'b1;
            end
            OP_HALT: begin
              w_state_next = S_HALT;
            end
            OP_LUT: begin
              ACC_WRITE = 1'b1;
              LOOKUP    = 1'b1;
              PC_EN     = 1'b1;
            end
            default: begin
              ACC_WRITE = 1'b1;
              PC_EN     = 1'b1;
            end
          endcase
        end
      end

      S_MEM_WAIT: begin
        MEM_READ    = 1'b1;
        IS_MEM      = 1'b1;
        w_wait_next = r_wait - 4'd1;
        // "<= 1" rather than "== 1" so a corrupted zero count cannot lock up.
        if (r_wait <= 4'd1) begin
          ACC_WRITE    = 1'b1;
          PC_EN        = 1'b1;
          w_wait_next  = 4'd0;
          w_state_next = S_RUN;
        end
      end

      S_HALT: begin
        done = 1'b1;
        if (Start) begin
          w_state_next = S_RUN;
          w_cnt_clr    = 1'b1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (w_cnt_clr) begin
        r_count <= '0;
      end else if (PC_EN && (r_count != {CNTW{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule
